axi_apb_port_arbiter: RTL
=========================

Name: axi_apb_port_arbiter

Overview:
Shares the single APB master engine of axi_apb_bridge between the four AXI slave ports S3..S6, mapped to requester indices 0..3. It arbitrates between AW and AR requests round-robin across ports and alternates read/write within a port. It holds a one-hot grant until the bridge engine reports transfer completion, or until a watchdog times out. It inserts one idle cycle between grants so PSEL always drops between transfers.

Parameters:
NUM_REQ, 4, number of AXI requester ports.
ID_W, $clog2(NUM_REQ), width of grant_id.
TIMEOUT_CYC, 256, maximum number of GRANT cycles before forced release; 0 disables the watchdog.

Ports:
axi_apb_clk  input  1  single clock; all logic on its rising edge.
axi_apb_sw_rst  input  1  reset, synchronous and active-high.
req_aw  input  NUM_REQ  per-port AWVALID (bit 0 = S3 ... bit 3 = S6).
req_ar  input  NUM_REQ  per-port ARVALID.
xfer_done  input  1  one-cycle pulse from the bridge engine on completion of the granted burst (last R beat or B accepted).
grant  output  NUM_REQ  one-hot grant; all-zero when idle.
grant_valid  output  1  equals |grant.
grant_id  output  ID_W  index of the granted port.
grant_wr  output  1  1 = granted operation is a write, 0 = read.
timeout  output  1  one-cycle pulse when the watchdog forces a release.
busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, highest priority, any state): next edge sets state=IDLE; grant=0, grant_valid=0, grant_id=0, grant_wr=0, timeout=0, busy=0. Round-robin pointer ptr=0, per-port last_wr bits=0, watchdog counter=0.
- States: IDLE, GRANT, GAP. All outputs are registered.
- IDLE: a port requests if req_aw[i]|req_ar[i]. If any port requests, the winner is the first requesting index at or after ptr, searching upward modulo NUM_REQ. Next edge: grant, grant_id and grant_wr are loaded, counter=0, state goes to GRANT. If no port requests, the block stays in IDLE.
- Op select for the winner:
  - only aw -> write.
  - only ar -> read.
  - both -> opposite of last_wr[winner]. last_wr=0 means write is chosen.
  - last_wr[winner] is updated to the chosen op.
- GRANT: grant, grant_id and grant_wr are frozen; requester deassertion does not affect them. The counter increments every cycle.
  - xfer_done=1 -> next edge: state=GAP, grant=0, ptr=(grant_id+1) mod NUM_REQ.
  - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 -> next edge: state=GAP, grant=0, timeout=1 for exactly that GAP cycle, ptr advanced as above.
  - xfer_done in the same cycle as terminal count: done wins, no timeout pulse.
- Grant duration under timeout: grant is high for exactly TIMEOUT_CYC cycles.
- GAP: one cycle with grant=0 and busy=1; xfer_done is ignored; always goes to IDLE.
- Latency:
  - A request sampled in IDLE gives grant visible 1 cycle later.
  - xfer_done sampled at edge N gives GAP in cycle N+1, IDLE in N+2, next grant in N+3.
- xfer_done in IDLE or GAP: ignored, no state change.
- Counter width is $clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- grant is always one-hot or zero. grant_id and grant_wr hold their last values while grant=0.

Test Plan:
1. Single request: reset released, req_aw=4'b0100 held -> one cycle later grant=4'b0100, grant_id=2, grant_wr=1. Grant holds for 10 cycles until xfer_done pulse; next cycle grant=0, busy=1 (GAP); next cycle busy=0.
2. Round-robin: req_ar=4'b1111 held, xfer_done pulsed 3 cycles into each grant -> grant_id sequence 0,1,2,3,0 with grant_wr=0 throughout. Grants are spaced exactly 3 cycles from done to next grant.
3. Intra-port alternation: req_aw[1]=req_ar[1]=1 held, other ports idle -> successive grants to port 1 with grant_wr=1,0,1,0.
4. Watchdog: TIMEOUT_CYC=16, req_ar[3]=1, no xfer_done -> grant=4'b1000 for exactly 16 cycles. Then timeout=1 for one cycle with grant=0; the following grant from req_ar=4'b1001 goes to port 0.
5. Collision: TIMEOUT_CYC=16, xfer_done asserted on the 16th grant cycle -> timeout stays 0; normal GAP then IDLE.
6. Reset mid-GRANT: axi_apb_sw_rst=1 for 1 cycle while grant=4'b0100 -> next edge all outputs 0. After release, req_aw=4'b1001 -> port 0 granted first with grant_wr=1.

Source files
------------

// File: rtl/axi_apb_port_arbiter.sv
// Round-robin arbiter sharing one APB master engine between NUM_REQ AXI ports.
// Grants are held until xfer_done or watchdog expiry, with one idle gap cycle between grants.
//
// state | meaning
// IDLE  | no grant; pick the next requester starting at the round-robin pointer
// GRANT | one-hot grant held; watchdog counting
// GAP   | single idle cycle so PSEL always drops between transfers
module axi_apb_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               axi_apb_clk,
    input  logic               axi_apb_sw_rst,
    input  logic [NUM_REQ-1:0] req_aw,
    input  logic [NUM_REQ-1:0] req_ar,
    input  logic               xfer_done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_wr,
    output logic               timeout,
    output logic               busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TC_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TC_LAST);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_grant_wr;
    logic               r_timeout;
    logic               r_busy;
    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] r_last_wr;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_req;
    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic [ID_W-1:0]    w_cand;
    logic               w_win_wr;
    logic               w_tc;
    logic [ID_W-1:0]    w_ptr_next;
    int                 w_idx;

    assign w_req = req_aw | req_ar;

    // First requesting index at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx  = (int'(r_ptr) + k) % NUM_REQ;
            w_cand = ID_W'(w_idx);
            if (!w_found && w_req[w_cand]) begin
                w_found  = 1'b1;
                w_win_id = w_cand;
            end
        end
    end

    // Both AW and AR pending: alternate, starting with write after reset.
    always_comb begin
        if (req_aw[w_win_id] && !req_ar[w_win_id])
            w_win_wr = 1'b1;
        else if (!req_aw[w_win_id] && req_ar[w_win_id])
            w_win_wr = 1'b0;
        else
            w_win_wr = ~r_last_wr[w_win_id];
    end

    assign w_tc       = (TIMEOUT_CYC != 0) && (r_cnt == TC_VAL);
    assign w_ptr_next = (r_grant_id == ID_LAST) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge axi_apb_clk) begin
        if (axi_apb_sw_rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_grant_wr    <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_ptr         <= '0;
            r_last_wr     <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_found) begin
                        r_state             <= GRANT;
                        r_grant             <= NUM_REQ'(1) << w_win_id;
                        r_grant_valid       <= 1'b1;
                        r_grant_id          <= w_win_id;
                        r_grant_wr          <= w_win_wr;
                        r_last_wr[w_win_id] <= w_win_wr;
                        r_cnt               <= '0;
                        r_busy              <= 1'b1;
                    end
                end
                GRANT: begin
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                    // Completion beats the watchdog when both land on the same cycle.
                    if (xfer_done || w_tc) begin
                        r_state       <= GAP;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= w_ptr_next;
                        r_timeout     <= ~xfer_done;
                    end
                end
                GAP: begin
                    r_state   <= IDLE;
                    r_timeout <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign grant_wr    = r_grant_wr;
    assign timeout     = r_timeout;
    assign busy        = r_busy;

endmodule
